// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: stretcher state encoding and default pulse timing.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEFAULT_HOLD_CYCLES = 4;
  localparam int DEFAULT_GAP_CYCLES  = 2;
  localparam int DEFAULT_CNT_W       = 8;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Request/indicator bundle between a pulse source and pulse_stretcher.
// InputPulse: each cycle sampled high is one request (no ready; overflow is reported on Dropped).
interface pulse_stretcher_if;
  import stopwatch_pkg::*;

  logic   InputPulse;
  logic   StretchOut;
  logic   Busy;
  logic   Dropped;
  state_t dbg_state;

  modport master (
    output InputPulse,
    input  StretchOut,
    input  Busy,
    input  Dropped,
    input  dbg_state
  );

  modport slave (
    input  InputPulse,
    output StretchOut,
    output Busy,
    output Dropped,
    output dbg_state
  );
endinterface

// File: rtl/pulse_stretch_counter.sv
// Loadable down-counter with zero flag, shared by the HOLD and GAP phases.
// Load wins over decrement; decrement stops at zero and never wraps.
module pulse_stretch_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle requests into HOLD_CYCLES-wide pulses with a GAP_CYCLES low gap,
// queueing one request. Build option PULSE_STRETCHER_RETRIGGER_EN: requests in HOLD extend the pulse.
module pulse_stretcher
  import stopwatch_pkg::*;
#(
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic               CLOCK,
  input  logic               Reset,
  pulse_stretcher_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t           state, state_n;
  logic             pending, pending_n;
  logic             dropped, dropped_n;
  logic             out_q, busy_q;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             queue_req;
  logic             req;

  assign req = bus.InputPulse;

  pulse_stretch_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (CLOCK),
    .rst      (Reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      dropped <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      dropped <= dropped_n;
      out_q   <= (state_n == ST_HOLD);
      busy_q  <= (state_n != ST_IDLE) | pending_n;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    dropped_n = dropped;
    cnt_load  = 1'b0;
    cnt_val   = HOLD_LOAD;
    cnt_dec   = 1'b0;
    queue_req = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req) begin
          state_n  = ST_HOLD;
          cnt_load = 1'b1;
        end
      end

      ST_HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (req) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
`else
        if (cnt_zero) begin
`endif
          if (GAP_CYCLES > 0) begin
            state_n   = ST_GAP;
            cnt_load  = 1'b1;
            cnt_val   = GAP_LOAD;
            queue_req = 1'b1;
          end else if (pending) begin
            // Back-to-back pulses merge; a new request re-queues behind the consumed one.
            cnt_load  = 1'b1;
            pending_n = req;
          end else if (req) begin
            cnt_load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_dec   = 1'b1;
          queue_req = 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_zero) begin
          if (pending) begin
            state_n   = ST_HOLD;
            cnt_load  = 1'b1;
            pending_n = req;
          end else if (req) begin
            state_n  = ST_HOLD;
            cnt_load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_dec   = 1'b1;
          queue_req = 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // One slot of queueing; anything beyond it is only flagged.
    if (queue_req && req) begin
      if (pending) begin
        dropped_n = 1'b1;
      end else begin
        pending_n = 1'b1;
      end
    end
  end

  assign bus.StretchOut = out_q;
  assign bus.Busy       = busy_q;
  assign bus.Dropped    = dropped;
  assign bus.dbg_state  = state;

endmodule
